// File: rtl/alu_div_unit.sv
// rtl/alu_div_unit.sv - iterative radix-2 restoring divide/remainder unit (DIV, REM, DIVU, REMU)
module alu_div_unit #(
  parameter int bits = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      s,
  input  logic [bits-1:0] x,
  input  logic [bits-1:0] y,
  output logic            busy,
  output logic            done,
  output logic [bits-1:0] z
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int              CW       = $clog2(bits + 1);
  localparam logic [CW-1:0]   CNT_INIT = CW'(bits);
  localparam logic [bits-1:0] MIN_VAL  = {1'b1, {(bits-1){1'b0}}};

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [bits-1:0] dvd_q, dvd_d;
  logic [bits-1:0] dvs_q, dvs_d;
  logic [bits-1:0] rem_q, rem_d;
  logic [bits-1:0] z_q, z_d;
  logic            op_rem_q, op_rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            div0_q, div0_d;
  logic            ovf_q, ovf_d;

  logic            is_div, is_signed, accept;
  logic            x_neg, y_neg;
  logic [bits-1:0] x_mag, y_mag;
  logic [bits:0]   trial, diff;
  logic            ge;
  logic [bits-1:0] q_fix, r_fix;

  always_comb begin
    is_div    = (s == 5'd8) || (s == 5'd9) || (s == 5'd22) || (s == 5'd23);
    is_signed = (s == 5'd8) || (s == 5'd9);
    accept    = start && is_div && (state_q != CALC);
    x_neg     = is_signed && x[bits-1];
    y_neg     = is_signed && y[bits-1];
    x_mag     = x_neg ? -x : x;
    y_mag     = y_neg ? -y : y;

    // The remainder stays below the divisor, so a successful trial subtract always fits in bits.
    trial = {rem_q, dvd_q[bits-1]};
    diff  = trial - {1'b0, dvs_q};
    ge    = trial >= {1'b0, dvs_q};

    q_fix = qneg_q ? -dvd_q : dvd_q;
    r_fix = rneg_q ? -rem_q : rem_q;
    if (div0_q) begin
      q_fix = '1;
    end
    if (ovf_q) begin
      q_fix = MIN_VAL;
      r_fix = '0;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    z_d      = z_q;
    op_rem_d = op_rem_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d  = CALC;
          cnt_d    = CNT_INIT;
          dvd_d    = x_mag;
          dvs_d    = y_mag;
          rem_d    = '0;
          op_rem_d = (s == 5'd9) || (s == 5'd23);
          qneg_d   = x_neg ^ y_neg;
          rneg_d   = x_neg;
          div0_d   = (y == '0);
          ovf_d    = is_signed && (x == MIN_VAL) && (y == '1);
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          // The dividend register doubles as the quotient: bits leave the top, quotient bits enter the bottom.
          rem_d = ge ? diff[bits-1:0] : trial[bits-1:0];
          dvd_d = {dvd_q[bits-2:0], ge};
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = DONE;
          z_d     = op_rem_q ? r_fix : q_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      z_q      <= '0;
      op_rem_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      z_q      <= z_d;
      op_rem_q <= op_rem_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == CALC);
  assign done = (state_q == DONE);
  assign z    = z_q;

endmodule

// File: tb/tb_alu_div_unit.sv
// tb/tb_alu_div_unit.sv - scoreboard bench for alu_div_unit with directed vectors
module tb_alu_div_unit;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [4:0]   s = 5'd0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic         busy, done;
  logic [W-1:0] z;

  alu_div_unit #(.bits(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(s),
    .x(x), .y(y), .busy(busy), .done(done), .z(z)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] z;
    int           cyc;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.name, "_z"}, z, e.z);
        check({e.name, "_latency"}, W'(cyc), W'(e.cyc));
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string name, input bit track);
    exp_t e;
    start = 1'b1;
    s = op;
    x = a;
    y = b;
    @(posedge clk);
    #1;
    if (track) begin
      e.z = exp;
      e.cyc = cyc + W + 1;
      e.name = name;
      q.push_back(e);
    end
    check({name, "_busy"}, W'(busy), W'(1));
    @(negedge clk);
    start = 1'b0;
    s = 5'd3;
    x = {$urandom, $urandom};
    y = {$urandom, $urandom};
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d outstanding expected 0", name, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{5'd8,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_m7_2"});
    vecs.push_back('{5'd9,  -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, "rem_m7_2"});
    vecs.push_back('{5'd23, 64'd7,   64'd2, 64'd1,                   "remu_7_2"});
    vecs.push_back('{5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, "divu_max_2"});
    vecs.push_back('{5'd8,  64'd7,  -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, "div_7_m2"});
    vecs.push_back('{5'd9,  64'd7,  -64'sd2, 64'd1,                   "rem_7_m2"});
    vecs.push_back('{5'd8,  64'd5,   64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "div_by0"});
    vecs.push_back('{5'd9,  64'd5,   64'd0, 64'd5,                   "rem_by0"});
    vecs.push_back('{5'd22, 64'd5,   64'd0, 64'hFFFF_FFFF_FFFF_FFFF, "divu_by0"});
    vecs.push_back('{5'd23, 64'd5,   64'd0, 64'd5,                   "remu_by0"});
    vecs.push_back('{5'd9,  -64'sd9, 64'd0, -64'sd9,                 "rem_neg_by0"});
    vecs.push_back('{5'd8,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, "div_ovf"});
    vecs.push_back('{5'd9,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, "rem_ovf"});

    #1;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_z", z, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);
      drain(vecs[i].name);
    end

    // Non-divide opcode is ignored.
    start = 1'b1;
    s = 5'd3;
    x = 64'd10;
    y = 64'd3;
    @(posedge clk);
    #1;
    check("bad_op_busy", W'(busy), W'(0));
    @(negedge clk);
    start = 1'b0;
    check("bad_op_busy_later", W'(busy), W'(0));

    // Start during CALC is ignored; original result and timing are kept.
    launch(5'd22, 64'd100, 64'd7, 64'd14, "ignore_in_calc", 1'b1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    s = 5'd8;
    x = 64'd1;
    y = 64'd1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore_in_calc");

    // Back-to-back: restart in the DONE cycle.
    launch(5'd23, 64'd7, 64'd2, 64'd1, "b2b_first", 1'b1);
    for (int i = 0; i < 100 && !done; i++) @(negedge clk);
    check("b2b_done_seen", W'(done), W'(1));
    launch(5'd22, 64'd100, 64'd7, 64'd14, "b2b_second", 1'b1);
    drain("b2b_second");

    // Reset mid-operation aborts with no done pulse.
    launch(5'd22, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, '0, "abort", 1'b0);
    repeat (18) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", W'(busy), W'(0));
    check("abort_done", W'(done), W'(0));
    check("abort_z", z, '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("abort_idle_busy", W'(busy), W'(0));

    // Unit still works after the abort.
    launch(5'd8, -64'sd100, 64'd7, -64'sd14, "after_abort", 1'b1);
    drain("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
